// File: rtl/uart_rx_fifo.sv
// -----------------------------------------------------------------------------
// uart_rx_fifo
// Receive-side character buffer of the UART IP. Characters arriving from the
// UART receiver are stored in a circular FIFO; the bus sees the head character
// at the data register and a status word at the status register. Each rising
// edge of a bus read of the data register pops exactly one character, so a
// read held for several cycles pops only once.
//
// Ports
//   i_clock        system clock, all state changes on its rising edge
//   i_reset        synchronous active-high reset
//   i_rx_data      character from the UART receiver
//   i_rx_valid     single-cycle strobe qualifying i_rx_data
//   i_read         bus read request (may be held for several cycles)
//   i_chip_select  bus chip select for this IP
//   i_address      register select: 00 data, 01 status, 10/11 reserved
//   o_read_data    bus read data (combinational mux of registered state)
//   o_empty        FIFO holds no entries
//   o_full         FIFO holds DEPTH entries
//   o_overflow     sticky: a character was dropped because the FIFO was full
//   o_count        number of entries currently stored
// -----------------------------------------------------------------------------
module uart_rx_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int ADDR_BITS  = 4
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic [DATA_WIDTH-1:0] i_rx_data,
  input  logic                  i_rx_valid,
  input  logic                  i_read,
  input  logic                  i_chip_select,
  input  logic [1:0]            i_address,
  output logic [31:0]           o_read_data,
  output logic                  o_empty,
  output logic                  o_full,
  output logic                  o_overflow,
  output logic [ADDR_BITS:0]    o_count
);

  localparam logic [ADDR_BITS-1:0] PTR_ONE  = {{(ADDR_BITS-1){1'b0}}, 1'b1};
  localparam logic [ADDR_BITS:0]   CNT_ONE  = {{ADDR_BITS{1'b0}}, 1'b1};
  localparam logic [ADDR_BITS:0]   CNT_FULL = (ADDR_BITS+1)'(DEPTH);

  logic [DATA_WIDTH-1:0] r_mem [0:DEPTH-1];
  logic [ADDR_BITS-1:0]  r_wr_ptr;
  logic [ADDR_BITS-1:0]  r_rd_ptr;
  logic [ADDR_BITS:0]    r_count;
  logic                  r_overflow;
  logic                  r_last_read;

  logic                  w_empty;
  logic                  w_full;
  logic                  w_read_edge;
  logic                  w_pop;
  logic                  w_push;
  logic                  w_drop;
  logic                  w_status_clr;
  logic [DATA_WIDTH-1:0] w_head;
  logic [31:0]           w_status;

  assign w_empty      = (r_count == {(ADDR_BITS+1){1'b0}});
  assign w_full       = (r_count == CNT_FULL);
  // r_last_read resets to 1 so a read held high across reset is not an edge.
  assign w_read_edge  = i_read & ~r_last_read & i_chip_select;
  assign w_pop        = w_read_edge & (i_address == 2'b00) & ~w_empty;
  // A pop in the same cycle frees the head slot, so a full FIFO still accepts.
  assign w_push       = i_rx_valid & (~w_full | w_pop);
  assign w_drop       = i_rx_valid & w_full & ~w_pop;
  assign w_status_clr = w_read_edge & (i_address == 2'b01);
  assign w_head       = r_mem[r_rd_ptr];

  // Storage array write; contents need no reset.
  always_ff @(posedge i_clock) begin
    if (w_push && !i_reset) begin
      r_mem[r_wr_ptr] <= i_rx_data;
    end
  end

  // Pointers, occupancy, sticky overflow and read-edge history.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_wr_ptr    <= {ADDR_BITS{1'b0}};
      r_rd_ptr    <= {ADDR_BITS{1'b0}};
      r_count     <= {(ADDR_BITS+1){1'b0}};
      r_overflow  <= 1'b0;
      r_last_read <= 1'b1;
    end else begin
      r_last_read <= i_read;

      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end

      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase

      // A drop in the same cycle as a status read-to-clear keeps the flag set.
      if (w_drop) begin
        r_overflow <= 1'b1;
      end else if (w_status_clr) begin
        r_overflow <= 1'b0;
      end
    end
  end

  // Status word assembly.
  always_comb begin
    w_status                 = 32'd0;
    w_status[ADDR_BITS+8:8]  = r_count;
    w_status[2]              = r_overflow;
    w_status[1]              = w_full;
    w_status[0]              = w_empty;
  end

  // Bus read data mux; the head is visible in the same cycle the read rises.
  always_comb begin
    o_read_data = 32'd0;
    if (i_chip_select) begin
      case (i_address)
        2'b00: begin
          if (!w_empty) begin
            o_read_data[DATA_WIDTH-1:0] = w_head;
          end else begin
            o_read_data = 32'd0;
          end
        end
        2'b01:   o_read_data = w_status;
        default: o_read_data = 32'd0;
      endcase
    end else begin
      o_read_data = 32'd0;
    end
  end

  assign o_empty    = w_empty;
  assign o_full     = w_full;
  assign o_overflow = r_overflow;
  assign o_count    = r_count;

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Receive-side buffer of the UART IP module, and the read-direction counterpart of the bus write strobe path.
- Accepts bytes from the UART receiver and stores them in a circular FIFO.
- Presents the head byte and a status word to the bus.
- Pops exactly one entry per bus read of the data register, detected on the rising edge of Read so that a multi-cycle read pops only once.

Parameters:
DATA_WIDTH, 8, width of one received character
DEPTH, 16, number of FIFO entries; power of two, 2..256
ADDR_BITS, 4, log2(DEPTH); width of the read/write pointers

Ports:
Clock  input  1  system clock; all state updates on its rising edge
Reset  input  1  synchronous, active-high reset
RxData  input  DATA_WIDTH  character from the UART receiver
RxValid  input  1  single-cycle strobe; RxData is valid this cycle
Read  input  1  bus read request; may be held high for several cycles
ChipSelect  input  1  bus chip select for this IP
Address  input  2  register select: 00 data, 01 status, 10/11 reserved
ReadData  output  32  bus read data (combinational mux of registered state)
Empty  output  1  FIFO holds zero entries
Full  output  1  FIFO holds DEPTH entries
Overflow  output  1  sticky flag: a character was dropped because the FIFO was full
Count  output  ADDR_BITS+1  number of entries currently stored

Behaviour:
- Reset is synchronous. When Reset is high at a rising edge:
  - write pointer = 0, read pointer = 0, Count = 0, Overflow = 0, lastRead = 1.
  - Resulting outputs: Empty = 1, Full = 0, ReadData = 0 for the data address.
  - Storage array contents are don't-care.
  - Reset mid-operation discards all stored entries and any pending pop.
- Read edge detection:
  - lastRead is a register that samples Read every cycle.
  - readEdge = Read & !lastRead & ChipSelect.
  - Because lastRead resets to 1, Read held high through reset produces no spurious pop.
- Pop:
  - pop = readEdge & (Address == 00) & !Empty.
  - On pop: read pointer increments mod DEPTH at the same clock edge.
  - During that cycle ReadData already shows the old head, so the bus samples the popped value. Read latency is 0; data is valid in the same cycle Read rises.
  - Pop while Empty: ignored, pointers unchanged, ReadData = 0.
- Push:
  - push = RxValid & (!Full | pop).
  - On push: RxData is written at the write pointer, and the write pointer increments mod DEPTH.
  - RxValid while Full and no pop in the same cycle: the character is dropped, the array is untouched, and Overflow is set to 1 at that edge.
- Simultaneous push and pop:
  - Both are performed and Count is unchanged.
  - This includes the Full case (the pop frees the slot first, so no overflow).
  - It also includes the single-entry case, where the new byte becomes the head.
- Count:
  - Count + push - pop, computed at ADDR_BITS+1 width.
  - Never exceeds DEPTH and never goes below 0.
  - Empty = (Count == 0); Full = (Count == DEPTH). Both are derived from the registered Count and carry no extra latency.
- Overflow clearing:
  - Overflow is sticky.
  - It is cleared by readEdge with Address == 01 (read-to-clear of status); the status word returned in that cycle still shows Overflow = 1.
  - If a drop and a status clear occur in the same cycle, set wins and Overflow stays 1.
- ReadData mux (only when ChipSelect = 1, else 0):
  - 00: {zeros, head byte}, or 0 when Empty.
  - 01: {zeros, Count at bits [ADDR_BITS+8:8], Overflow at bit 2, Full at bit 1, Empty at bit 0}.
  - 10/11: 0.
- Pointer wrap: pointers wrap from DEPTH-1 to 0 with no gap. Ordering is strictly first-in-first-out across the wrap.

Test Plan:
1. Reset, then drive Read = 1 with Address 00 held through release of reset → no pop. Empty = 1, Count = 0, ReadData = 0x00000000.
2. Push 0x41, 0x42, 0x43, then hold Read high for 4 cycles at Address 00 → ReadData = 0x41 and exactly one pop. Count goes 3 → 2. Next rising Read returns 0x42.
3. Push 20 bytes 0x00..0x13 with DEPTH = 16 → Full = 1, Count = 16, Overflow = 1. Sixteen pops return 0x00..0x0F in order, then Empty = 1.
4. With Full = 1, assert RxValid = 0xAA in the same cycle as a data-register read edge → head is popped, 0xAA is accepted, Count stays 16, Overflow is unchanged (0 if previously clear).
5. With Overflow = 1, read edge at Address 01 → returned status has bit 2 = 1. Next status read shows bit 2 = 0. Repeat with a simultaneous dropped RxValid → bit 2 stays 1.
6. Push/pop 40 bytes interleaved so that the pointers wrap twice → output sequence equals input sequence. Assert Reset mid-stream with Count = 5 → next cycle Count = 0, Empty = 1, Overflow = 0.
